demux_1to5: RTL and testbench

Per-router output-side distributor for the NoC: takes one incoming flit stream with a valid/ready handshake and steers each packet to one of five directional outputs (North, South, West, East, Local). It is the counterpart of the 5-to-1 input mux. It uses the same 3-bit port encoding. Wormhole routing applies: the head flit's destination is locked until the tail flit passes. Each output has a one-entry registered slot, so downstream ports stall independently.

---
 rtl/noc_pkg.sv | 27 ++
 rtl/out_slot.sv | 44 ++++
 rtl/demux_1to5.sv | 148 ++++++++++++++
 tb/tb_demux_1to5.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg
// Shared NoC router definitions: the 3-bit directional port encoding used by
// both the 1-to-5 demux and the 5-to-1 mux, the port count, the demux FSM
// state type and a helper that qualifies a destination code.
package noc_pkg;

    localparam int unsigned NUM_PORTS = 5;

    typedef enum logic [2:0] {
        N = 3'd0,
        S = 3'd1,
        W = 3'd2,
        E = 3'd3,
        L = 3'd4
    } port_e;

    typedef enum logic {
        StIdle,
        StLocked
    } demux_state_e;

    // Codes 5..7 do not name a direction.
    function automatic logic is_valid_port(input logic [2:0] port);
        return port <= 3'd4;
    endfunction

endpackage

// File: rtl/out_slot.sv
// out_slot
// One-entry registered output slot with a valid/ready handshake.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   wr_i, data_i    write strobe and payload from the distributor
//   valid_o, data_o registered output towards downstream
//   ready_i         downstream ready
//   can_accept_o    slot can take a write this cycle (empty or draining)
module out_slot
    import noc_pkg::*;
#(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              can_accept_o
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Pass-through drain: a full slot being emptied this cycle can be refilled.
    assign can_accept_o = !r_valid || ready_i;
    assign valid_o      = r_valid;
    assign data_o       = r_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (wr_i) begin
            r_valid <= 1'b1;
            r_data  <= data_i;
        end else if (r_valid && ready_i) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1to5.sv
// demux_1to5
// Router output-side distributor. Steers each wormhole packet from a single
// valid/ready flit stream to one of five directional slots (N, S, W, E, L).
// The head flit picks the destination, which stays locked until the tail.
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   data_i, valid_i, ready_o    incoming flit handshake
//   head_i, tail_i, dest_i      flit framing and head destination
//   data_x_o, valid_x_o         per-direction registered outputs
//   ready_x_i                   per-direction downstream ready
//   lock_o                      packet in progress
//   err_o                       one-cycle pulse after a flit is dropped
module demux_1to5
    import noc_pkg::*;
#(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              head_i,
    input  logic              tail_i,
    input  logic [2:0]        dest_i,
    output logic [DATA_W-1:0] data_n_o,
    output logic [DATA_W-1:0] data_s_o,
    output logic [DATA_W-1:0] data_w_o,
    output logic [DATA_W-1:0] data_e_o,
    output logic [DATA_W-1:0] data_l_o,
    output logic              valid_n_o,
    output logic              valid_s_o,
    output logic              valid_w_o,
    output logic              valid_e_o,
    output logic              valid_l_o,
    input  logic              ready_n_i,
    input  logic              ready_s_i,
    input  logic              ready_w_i,
    input  logic              ready_e_i,
    input  logic              ready_l_i,
    output logic              lock_o,
    output logic              err_o
);

    demux_state_e r_state, w_state_d;
    logic [2:0]   r_cur_dest, w_cur_dest_d;
    logic         r_err;

    logic [NUM_PORTS-1:0] w_slot_ready;
    logic [NUM_PORTS-1:0] w_slot_valid;
    logic [NUM_PORTS-1:0] w_slot_can;
    logic [NUM_PORTS-1:0] w_slot_wr;
    logic [DATA_W-1:0]    w_slot_data [NUM_PORTS];

    logic [2:0] w_sel;
    logic       w_sel_can;
    logic       w_head_ok;
    logic       w_accept;
    logic       w_write;
    logic       w_drop;

    assign w_slot_ready = {ready_l_i, ready_e_i, ready_w_i, ready_s_i, ready_n_i};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_slot
        out_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .wr_i        (w_slot_wr[p]),
            .data_i      (data_i),
            .ready_i     (w_slot_ready[p]),
            .valid_o     (w_slot_valid[p]),
            .data_o      (w_slot_data[p]),
            .can_accept_o(w_slot_can[p])
        );
    end

    always_comb begin
        w_sel        = (r_state == StLocked) ? r_cur_dest : dest_i;
        w_head_ok    = head_i && is_valid_port(dest_i);
        w_sel_can    = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_sel == 3'(p)) begin
                w_sel_can = w_slot_can[p];
            end
        end

        // Flits that will be dropped are always taken so the stream never wedges.
        if (r_state == StLocked) begin
            ready_o = w_sel_can;
        end else begin
            ready_o = w_head_ok ? w_sel_can : 1'b1;
        end

        w_accept = valid_i && ready_o;
        w_write  = w_accept && ((r_state == StLocked) || w_head_ok);
        w_drop   = w_accept && (r_state == StIdle) && !w_head_ok;

        for (int p = 0; p < NUM_PORTS; p++) begin
            w_slot_wr[p] = w_write && (w_sel == 3'(p));
        end

        w_state_d    = r_state;
        w_cur_dest_d = r_cur_dest;
        unique case (r_state)
            StIdle: begin
                if (w_write && !tail_i) begin
                    w_state_d    = StLocked;
                    w_cur_dest_d = dest_i;
                end
            end
            StLocked: begin
                if (w_accept && tail_i) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= StIdle;
            r_cur_dest <= 3'd0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cur_dest <= w_cur_dest_d;
            r_err      <= w_drop;
        end
    end

    assign lock_o    = (r_state == StLocked);
    assign err_o     = r_err;

    assign valid_n_o = w_slot_valid[0];
    assign valid_s_o = w_slot_valid[1];
    assign valid_w_o = w_slot_valid[2];
    assign valid_e_o = w_slot_valid[3];
    assign valid_l_o = w_slot_valid[4];
    assign data_n_o  = w_slot_data[0];
    assign data_s_o  = w_slot_data[1];
    assign data_w_o  = w_slot_data[2];
    assign data_e_o  = w_slot_data[3];
    assign data_l_o  = w_slot_data[4];

endmodule

// File: tb/tb_demux_1to5.sv
module tb_demux_1to5;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] data_i;
    logic       valid_i, head_i, tail_i;
    logic [2:0] dest_i;
    logic       ready_o, lock_o, err_o;
    logic [3:0] data_n_o, data_s_o, data_w_o, data_e_o, data_l_o;
    logic       valid_n_o, valid_s_o, valid_w_o, valid_e_o, valid_l_o;
    logic       ready_n_i, ready_s_i, ready_w_i, ready_e_i, ready_l_i;

    always #5 clk_i = ~clk_i;

    demux_1to5 #(.DATA_W(4)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .head_i   (head_i),
        .tail_i   (tail_i),
        .dest_i   (dest_i),
        .data_n_o (data_n_o),
        .data_s_o (data_s_o),
        .data_w_o (data_w_o),
        .data_e_o (data_e_o),
        .data_l_o (data_l_o),
        .valid_n_o(valid_n_o),
        .valid_s_o(valid_s_o),
        .valid_w_o(valid_w_o),
        .valid_e_o(valid_e_o),
        .valid_l_o(valid_l_o),
        .ready_n_i(ready_n_i),
        .ready_s_i(ready_s_i),
        .ready_w_i(ready_w_i),
        .ready_e_i(ready_e_i),
        .ready_l_i(ready_l_i),
        .lock_o   (lock_o),
        .err_o    (err_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard: one expected-data queue per direction.
    logic [3:0] q_n[$], q_s[$], q_w[$], q_e[$], q_l[$];

    // Reference model state.
    logic       exp_lock = 1'b0;
    logic [2:0] exp_cur  = 3'd0;
    int         n_drops  = 0;
    int         mon_drops_seen = 0;
    int         lock_cycles = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int qsize(input int p);
        case (p)
            0: return q_n.size();
            1: return q_s.size();
            2: return q_w.size();
            3: return q_e.size();
            default: return q_l.size();
        endcase
    endfunction

    task automatic push(input int p, input logic [3:0] d);
        case (p)
            0: q_n.push_back(d);
            1: q_s.push_back(d);
            2: q_w.push_back(d);
            3: q_e.push_back(d);
            default: q_l.push_back(d);
        endcase
    endtask

    task automatic pop(input int p, output logic [3:0] d);
        case (p)
            0: d = q_n.pop_front();
            1: d = q_s.pop_front();
            2: d = q_w.pop_front();
            3: d = q_e.pop_front();
            default: d = q_l.pop_front();
        endcase
    endtask

    task automatic mon_port(input int p, input string tag, input logic v, input logic r,
                            input logic [3:0] d);
        logic [3:0] e;
        if (v && r) begin
            check({tag, "_expected"}, 32'(qsize(p) != 0), 1);
            if (qsize(p) != 0) begin
                pop(p, e);
                check({tag, "_data"}, d, e);
            end
        end
    endtask

    // Samples mid-cycle; a valid&&ready seen here transfers at the next rising edge.
    task automatic monitor();
        forever begin
            @(negedge clk_i);
            mon_port(0, "n", valid_n_o, ready_n_i, data_n_o);
            mon_port(1, "s", valid_s_o, ready_s_i, data_s_o);
            mon_port(2, "w", valid_w_o, ready_w_i, data_w_o);
            mon_port(3, "e", valid_e_o, ready_e_i, data_e_o);
            mon_port(4, "l", valid_l_o, ready_l_i, data_l_o);
            check("lock", lock_o, exp_lock);
            check("err", err_o, 32'(n_drops != mon_drops_seen));
            mon_drops_seen = n_drops;
            if (lock_o) lock_cycles++;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic h, input logic t, input logic [2:0] d,
                        input logic [3:0] x, output int waited);
        logic drop;
        head_i  = h;
        tail_i  = t;
        dest_i  = d;
        data_i  = x;
        valid_i = 1'b1;
        waited  = 0;
        @(negedge clk_i);
        while (!ready_o && waited < 50) begin
            waited++;
            @(negedge clk_i);
        end
        if (!ready_o) begin
            check("ready_timeout", ready_o, 1);
            @(posedge clk_i);
            #1 valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        drop = 1'b0;
        if (exp_lock) begin
            push(int'(exp_cur), x);
            if (t) exp_lock = 1'b0;
        end else if (h && d <= 3'd4) begin
            push(int'(d), x);
            if (!t) begin
                exp_lock = 1'b1;
                exp_cur  = d;
            end
        end else begin
            drop = 1'b1;
        end
        if (drop) n_drops++;
        #1;
        valid_i = 1'b0;
        head_i  = 1'b0;
        tail_i  = 1'b0;
    endtask

    task automatic check_no_valids(input string tag);
        check(tag, {valid_n_o, valid_s_o, valid_w_o, valid_e_o, valid_l_o}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, wa, wb, c0;
        rst_ni = 1'b0;
        valid_i = 1'b0; head_i = 1'b0; tail_i = 1'b0; dest_i = 3'd0; data_i = 4'd0;
        ready_n_i = 1'b1; ready_s_i = 1'b1; ready_w_i = 1'b1; ready_e_i = 1'b1;
        ready_l_i = 1'b1;
        fork
            monitor();
        join_none

        // Reset state
        #12;
        check_no_valids("rst_valids");
        check("rst_data", {data_n_o, data_s_o, data_w_o, data_e_o, data_l_o}, 0);
        check("rst_lock", lock_o, 0);
        check("rst_err", err_o, 0);
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Single-flit packet to E
        send(1'b1, 1'b1, 3'b011, 4'b0101, w);
        check("e_valid", valid_e_o, 1);
        check("e_data", data_e_o, 4'b0101);
        check("e_others", {valid_n_o, valid_s_o, valid_w_o, valid_l_o}, 0);
        check("e_lock", lock_o, 0);

        // 3-flit packet to L; body carries dest 000 which must be ignored
        c0 = lock_cycles;
        send(1'b1, 1'b0, 3'b100, 4'b0001, w);
        send(1'b0, 1'b0, 3'b000, 4'b0010, w);
        send(1'b0, 1'b1, 3'b000, 4'b0100, w);
        repeat (2) @(negedge clk_i);
        check("l_lock_cycles", lock_cycles - c0, 2);
        check("l_delivered", qsize(4), 0);
        @(posedge clk_i);
        #1;

        // Back-pressure on W
        ready_w_i = 1'b0;
        send(1'b1, 1'b0, 3'b010, 4'hA, w);
        fork
            begin
                send(1'b0, 1'b0, 3'b000, 4'hB, wa);
                send(1'b0, 1'b1, 3'b000, 4'hC, wb);
            end
            begin
                repeat (3) @(negedge clk_i);
                check("bp_ready", ready_o, 0);
                check("bp_valid", valid_w_o, 1);
                check("bp_hold", data_w_o, 4'hA);
                @(posedge clk_i);
                #1 ready_w_i = 1'b1;
            end
        join
        check("bp_waited", 32'(wa >= 3), 1);
        repeat (3) @(negedge clk_i);
        check("bp_drained", qsize(2), 0);
        @(posedge clk_i);
        #1;

        // Invalid-destination head
        send(1'b1, 1'b1, 3'b110, 4'h7, w);
        check("inv_ready", w, 0);
        check_no_valids("inv_no_valid");
        @(negedge clk_i);
        check("inv_err_pulse", err_o, 1);
        @(negedge clk_i);
        check("inv_err_once", err_o, 0);
        @(posedge clk_i);
        #1;

        // Body flit while idle
        send(1'b0, 1'b0, 3'b001, 4'h9, w);
        check("body_ready", w, 0);
        @(negedge clk_i);
        check("body_err", err_o, 1);
        check_no_valids("body_no_valid");
        @(posedge clk_i);
        #1;

        // Reset mid-packet
        ready_s_i = 1'b0;
        send(1'b1, 1'b0, 3'b001, 4'h5, w);
        check("mid_valid_s", valid_s_o, 1);
        check("mid_lock", lock_o, 1);
        #2;
        rst_ni = 1'b0;
        exp_lock = 1'b0;
        q_s.delete();
        #1;
        check_no_valids("mid_rst_valids");
        check("mid_rst_lock", lock_o, 0);
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        ready_s_i = 1'b1;
        @(posedge clk_i);
        #1;
        send(1'b0, 1'b1, 3'b001, 4'h6, w);
        @(negedge clk_i);
        check("mid_drop_err", err_o, 1);
        check_no_valids("mid_drop_no_valid");
        @(posedge clk_i);
        #1;

        // Independent drain: N held, S delivered
        ready_n_i = 1'b0;
        send(1'b1, 1'b1, 3'b000, 4'h3, w);
        send(1'b1, 1'b1, 3'b001, 4'h6, w);
        repeat (2) @(negedge clk_i);
        check("ind_s_done", qsize(1), 0);
        check("ind_n_held", valid_n_o, 1);
        check("ind_n_data", data_n_o, 4'h3);
        @(posedge clk_i);
        #1 ready_n_i = 1'b1;
        repeat (3) @(negedge clk_i);

        // Nothing lost or left over
        for (int p = 0; p < 5; p++) begin
            check($sformatf("final_q%0d", p), qsize(p), 0);
        end
        check_no_valids("final_valids");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
